// File: rtl/kernel_job_dispatcher.sv
// Kernel job dispatcher: queues descriptors in a small FIFO, issues one job at a
// time to the kernel adaptor and returns tagged completion words downstream.
module kernel_job_dispatcher #(
   parameter int DSC_WIDTH      = 1024,
   parameter int READREG_NUMBER = 1,
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         dsc_valid,
   output logic                         dsc_ready,
   input  logic [DSC_WIDTH-1:0]         dsc_data,
   output logic                         kernel_start,
   input  logic                         kernel_ready,
   output logic [DSC_WIDTH-1:0]         kernel_data,
   input  logic                         complete_ready,
   output logic                         complete_accept,
   input  logic [READREG_NUMBER*32-1:0] complete_data,
   output logic                         cpl_valid,
   input  logic                         cpl_ready,
   output logic [READREG_NUMBER*32-1:0] cpl_data,
   output logic [7:0]                   cpl_tag,
   output logic                         busy,
   output logic [CNT_W-1:0]             fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, WAIT_CPL, DRAIN} state_t;

   state_t                      state_q, state_d;
   logic [DSC_WIDTH-1:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]            count_q;
   logic [7:0]                  job_tag_q, tag_q;
   logic [DSC_WIDTH-1:0]        kernel_data_q;
   logic                        cpl_valid_q;
   logic [READREG_NUMBER*32-1:0] cpl_data_q;
   logic [7:0]                  cpl_tag_q;
   logic                        push, pop, cpl_capture, cpl_handshake;

   // Handshakes: a transfer happens on a rising edge where valid & ready are
   // both high; valid, once raised, holds its payload until that edge.
   assign dsc_ready     = (count_q < DEPTH_C);
   assign push          = dsc_valid & dsc_ready;
   assign pop           = (state_q == IDLE) & (count_q != '0) & kernel_ready;
   assign cpl_capture   = (state_q == WAIT_CPL) & complete_ready;
   assign cpl_handshake = cpl_valid_q & cpl_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (pop)           state_d = START;
         START:                       state_d = WAIT_CPL;
         WAIT_CPL: if (cpl_capture)   state_d = DRAIN;
         DRAIN:    if (cpl_handshake) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Storage needs no reset: only slots covered by the count are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= dsc_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kernel_data_q <= '0;
         job_tag_q     <= '0;
         tag_q         <= '0;
      end else if (pop) begin
         kernel_data_q <= mem[rd_ptr_q];
         tag_q         <= job_tag_q;
         job_tag_q     <= job_tag_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpl_valid_q <= 1'b0;
         cpl_data_q  <= '0;
         cpl_tag_q   <= '0;
      end else if (cpl_capture) begin
         cpl_valid_q <= 1'b1;
         cpl_data_q  <= complete_data;
         cpl_tag_q   <= tag_q;
      end else if (cpl_handshake) begin
         cpl_valid_q <= 1'b0;
      end
   end

   assign kernel_start    = (state_q == START);
   assign kernel_data     = kernel_data_q;
   assign complete_accept = cpl_capture;
   assign cpl_valid       = cpl_valid_q;
   assign cpl_data        = cpl_data_q;
   assign cpl_tag         = cpl_tag_q;
   assign busy            = (state_q != IDLE) | (count_q != '0);
   assign fifo_count      = count_q;

endmodule

// File: tb/tb_kernel_job_dispatcher.sv
// Directed bench for kernel_job_dispatcher: single job, FIFO full, backpressure,
// simultaneous push/pop, reset mid-job and tag wrap, with an expected-descriptor queue.
module tb_kernel_job_dispatcher;

   localparam int DSC_W = 1024;
   localparam int CPL_W = 32;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             dsc_valid;
   logic             dsc_ready;
   logic [DSC_W-1:0] dsc_data;
   logic             kernel_start;
   logic             kernel_ready;
   logic [DSC_W-1:0] kernel_data;
   logic             complete_ready;
   logic             complete_accept;
   logic [CPL_W-1:0] complete_data;
   logic             cpl_valid;
   logic             cpl_ready;
   logic [CPL_W-1:0] cpl_data;
   logic [7:0]       cpl_tag;
   logic             busy;
   logic [CNT_W-1:0] fifo_count;

   int               checks = 0;
   int               errors = 0;
   logic [7:0]       tag_model = 8'd0;
   logic [DSC_W-1:0] exp_q[$];

   kernel_job_dispatcher #(
      .DSC_WIDTH(DSC_W), .READREG_NUMBER(1), .FIFO_DEPTH(4), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .dsc_valid(dsc_valid), .dsc_ready(dsc_ready), .dsc_data(dsc_data),
      .kernel_start(kernel_start), .kernel_ready(kernel_ready), .kernel_data(kernel_data),
      .complete_ready(complete_ready), .complete_accept(complete_accept),
      .complete_data(complete_data),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data), .cpl_tag(cpl_tag),
      .busy(busy), .fifo_count(fifo_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DSC_W-1:0] act, input logic [DSC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, act[127:0], exp[127:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DSC_W-1:0] mk_dsc(input logic [7:0] b);
      return {128{b}};
   endfunction

   task automatic check_reset_values();
      check("rst_dsc_ready", DSC_W'(dsc_ready), 1);
      check("rst_kernel_start", DSC_W'(kernel_start), 0);
      check("rst_kernel_data", kernel_data, 0);
      check("rst_complete_accept", DSC_W'(complete_accept), 0);
      check("rst_cpl_valid", DSC_W'(cpl_valid), 0);
      check("rst_cpl_data", DSC_W'(cpl_data), 0);
      check("rst_cpl_tag", DSC_W'(cpl_tag), 0);
      check("rst_busy", DSC_W'(busy), 0);
      check("rst_fifo_count", DSC_W'(fifo_count), 0);
   endtask

   // driver: offer one descriptor and hold it until accepted
   task automatic push_dsc(input logic [DSC_W-1:0] d);
      bit done = 0;
      dsc_valid = 1'b1;
      dsc_data  = d;
      for (int k = 0; k < 20 && !done; k++) begin
         done = dsc_ready;
         step();
      end
      dsc_valid = 1'b0;
      if (!done) check("push_timeout", 0, 1);
      else exp_q.push_back(d);
   endtask

   // called in the cycle where kernel_start must be high
   task automatic check_start();
      logic [DSC_W-1:0] exp_d;
      check("kernel_start", DSC_W'(kernel_start), 1);
      if (exp_q.size() == 0) begin
         check("start_unexpected", 1, 0);
      end else begin
         exp_d = exp_q.pop_front();
         check("kernel_data", kernel_data, exp_d);
      end
   endtask

   // find the next start, check it, and move into WAIT_CPL
   task automatic wait_start();
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (kernel_start) seen = 1;
         else step();
      end
      if (!seen) check("start_timeout", 0, 1);
      else check_start();
      step();
      check("start_one_cycle", DSC_W'(kernel_start), 0);
   endtask

   // entered in WAIT_CPL; completes and drains one job, optionally backpressured
   task automatic finish_job(input logic [CPL_W-1:0] word, input int hold);
      check("accept_before_ready", DSC_W'(complete_accept), 0);
      complete_ready = 1'b1;
      complete_data  = word;
      #1;
      check("complete_accept", DSC_W'(complete_accept), 1);
      step();
      complete_ready = 1'b0;
      complete_data  = '0;
      check("accept_one_cycle", DSC_W'(complete_accept), 0);
      check("cpl_valid", DSC_W'(cpl_valid), 1);
      check("cpl_data", DSC_W'(cpl_data), DSC_W'(word));
      check("cpl_tag", DSC_W'(cpl_tag), DSC_W'(tag_model));
      for (int k = 0; k < hold; k++) begin
         step();
         check("bp_cpl_valid", DSC_W'(cpl_valid), 1);
         check("bp_cpl_data", DSC_W'(cpl_data), DSC_W'(word));
         check("bp_no_start", DSC_W'(kernel_start), 0);
      end
      cpl_ready = 1'b1;
      step();
      cpl_ready = 1'b0;
      check("cpl_valid_clear", DSC_W'(cpl_valid), 0);
      tag_model = tag_model + 8'd1;
   endtask

   initial begin
      reset = 1'b1;
      dsc_valid = 1'b0; dsc_data = '0; kernel_ready = 1'b0;
      complete_ready = 1'b0; complete_data = '0; cpl_ready = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      check_reset_values();

      // single job
      kernel_ready = 1'b1;
      push_dsc(mk_dsc(8'hA5));
      check("sj_count", DSC_W'(fifo_count), 1);
      check("sj_no_start_yet", DSC_W'(kernel_start), 0);
      check("sj_busy", DSC_W'(busy), 1);
      step();
      check_start();
      check("sj_count_popped", DSC_W'(fifo_count), 0);
      step();
      check("sj_start_low", DSC_W'(kernel_start), 0);
      check("sj_data_hold", kernel_data, mk_dsc(8'hA5));
      finish_job(32'h0000_1234, 0);

      // FIFO full
      kernel_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_dsc(mk_dsc(8'h10 + 8'(i)));
      check("full_count", DSC_W'(fifo_count), 4);
      check("full_dsc_ready", DSC_W'(dsc_ready), 0);
      dsc_valid = 1'b1;
      dsc_data  = mk_dsc(8'h14);
      repeat (3) step();
      check("full_stall_count", DSC_W'(fifo_count), 4);
      check("full_stall_no_start", DSC_W'(kernel_start), 0);
      kernel_ready = 1'b1;
      step();
      check_start();
      check("full_pop_count", DSC_W'(fifo_count), 3);
      check("full_ready_again", DSC_W'(dsc_ready), 1);
      step();
      dsc_valid = 1'b0;
      exp_q.push_back(mk_dsc(8'h14));
      check("full_refill_count", DSC_W'(fifo_count), 4);
      finish_job(32'hF000_0000, 0);
      for (int i = 1; i < 5; i++) begin
         step();
         check_start();
         step();
         finish_job(32'hF000_0000 + 32'(i), 0);
      end
      check("full_drained", DSC_W'(busy), 0);

      // backpressure
      kernel_ready = 1'b0;
      push_dsc(mk_dsc(8'h20));
      push_dsc(mk_dsc(8'h21));
      kernel_ready = 1'b1;
      wait_start();
      finish_job(32'hBEEF_0001, 10);
      step();
      check_start();
      step();
      finish_job(32'hBEEF_0002, 0);

      // simultaneous push/pop
      kernel_ready = 1'b0;
      push_dsc(mk_dsc(8'h30));
      push_dsc(mk_dsc(8'h31));
      check("pp_count_before", DSC_W'(fifo_count), 2);
      dsc_valid = 1'b1;
      dsc_data  = mk_dsc(8'h32);
      kernel_ready = 1'b1;
      step();
      dsc_valid = 1'b0;
      exp_q.push_back(mk_dsc(8'h32));
      check("pp_count_same", DSC_W'(fifo_count), 2);
      check_start();
      step();
      finish_job(32'h5555_0000, 0);
      for (int i = 1; i < 3; i++) begin
         step();
         check_start();
         step();
         finish_job(32'h5555_0000 + 32'(i), 0);
      end

      // reset mid-job
      kernel_ready = 1'b0;
      push_dsc(mk_dsc(8'h40));
      push_dsc(mk_dsc(8'h41));
      push_dsc(mk_dsc(8'h42));
      kernel_ready = 1'b1;
      wait_start();
      check("mid_count", DSC_W'(fifo_count), 2);
      kernel_ready = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_values();
      step();
      reset = 1'b0;
      exp_q.delete();
      tag_model = 8'd0;
      check_reset_values();
      complete_ready = 1'b1;
      complete_data  = 32'hDEAD_BEEF;
      #1;
      check("mid_no_accept", DSC_W'(complete_accept), 0);
      step();
      complete_ready = 1'b0;
      complete_data  = '0;
      check("mid_no_cpl_valid", DSC_W'(cpl_valid), 0);

      // tag wrap: 257 jobs after reset, tags 0..255 then 0
      kernel_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         push_dsc(mk_dsc(8'(i)));
         wait_start();
         finish_job(32'hC0DE_0000 | 32'(i), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
